// File: rtl/mux16_b3.sv
`default_nettype none
// ============================================================================
// Module   : mux16_b3
// Purpose  : 3-to-1 operand multiplexer with a registered output. Select code
//            3 is illegal and loads zero. Defining MUX16B3_SEL_ERR_EN adds a
//            registered sel_err flag for the illegal code.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_b3 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       set,
    output logic [WIDTH-1:0] r
`ifdef MUX16B3_SEL_ERR_EN
    ,
    output logic             sel_err
`endif
);

    localparam logic [1:0] c_sel_in0 = 2'b00;
    localparam logic [1:0] c_sel_in1 = 2'b01;
    localparam logic [1:0] c_sel_in2 = 2'b10;

    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = '0;
        case (set)
            c_sel_in0: w_next = in0;
            c_sel_in1: w_next = in1;
            c_sel_in2: w_next = in2;
            default:   w_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else begin
            r <= w_next;
        end
    end

`ifdef MUX16B3_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= (set == 2'b11);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && set == 2'b11)
            $display("mux16_b3: warning: illegal select code 3 sampled at %0t", $time);
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux16_b3.sv
`default_nettype none
// Directed self-checking bench for mux16_b3.
module tb_mux16_b3;

    logic        clk;
    logic        reset;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [1:0]  set;
    logic [15:0] r;
`ifdef MUX16B3_SEL_ERR_EN
    logic        sel_err;
`endif

    int checks;
    int failures;

    mux16_b3 #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .set    (set),
        .r      (r)
`ifdef MUX16B3_SEL_ERR_EN
        ,
        .sel_err(sel_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in0 = 16'd1; in1 = 16'd3; in2 = 16'd7; set = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (r !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: r=%h expected=%h", i, r, 16'h0000);
            end
`ifdef MUX16B3_SEL_ERR_EN
            checks++;
            if (sel_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_sel_err[%0d]: sel_err=%b expected=0", i, sel_err);
            end
`endif
        end
        reset = 1'b0;
        tick();
        checks++;
        if (r !== 16'h0001) begin
            failures++;
            $display("FAIL reset_release: r=%h expected=%h", r, 16'h0001);
        end
    endtask

    task automatic test_channel_sweep();
        logic [15:0] exp_tab [3];
        exp_tab[0] = 16'd1; exp_tab[1] = 16'd3; exp_tab[2] = 16'd7;
        in0 = 16'd1; in1 = 16'd3; in2 = 16'd7;
        for (int s = 0; s < 3; s++) begin
            set = s[1:0];
            for (int h = 0; h < 2; h++) begin
                tick();
                checks++;
                if (r !== exp_tab[s]) begin
                    failures++;
                    $display("FAIL sweep set=%0d edge=%0d: r=%h expected=%h", s, h, r, exp_tab[s]);
                end
            end
        end
    endtask

    task automatic test_illegal_wrap();
        logic [2:0]  src;
        logic [15:0] exp_tab [4];
        exp_tab[0] = 16'd1; exp_tab[1] = 16'd3; exp_tab[2] = 16'd7; exp_tab[3] = 16'd0;
        in0 = 16'd1; in1 = 16'd3; in2 = 16'd7;
        set = 2'd3;
        tick();
        checks++;
        if (r !== 16'h0000) begin
            failures++;
            $display("FAIL illegal_code: r=%h expected=%h", r, 16'h0000);
        end
`ifdef MUX16B3_SEL_ERR_EN
        checks++;
        if (sel_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_sel_err: sel_err=%b expected=1", sel_err);
        end
`endif
        for (int v = 4; v < 8; v++) begin
            src = v[2:0];
            set = src[1:0];
            tick();
            checks++;
            if (r !== exp_tab[v-4]) begin
                failures++;
                $display("FAIL wrap src=%0d: r=%h expected=%h", v, r, exp_tab[v-4]);
            end
`ifdef MUX16B3_SEL_ERR_EN
            checks++;
            if (sel_err !== (v == 7)) begin
                failures++;
                $display("FAIL wrap_sel_err src=%0d: sel_err=%b expected=%b", v, sel_err, (v == 7));
            end
`endif
        end
    endtask

    task automatic test_latency_hold();
        in1 = 16'd3;
        set = 2'd1;
        tick();
        checks++;
        if (r !== 16'd3) begin
            failures++;
            $display("FAIL hold_setup: r=%h expected=%h", r, 16'd3);
        end
        #2;
        in1 = 16'hFFFF;
        #1;
        checks++;
        if (r !== 16'd3) begin
            failures++;
            $display("FAIL hold_midcycle: r=%h expected=%h", r, 16'd3);
        end
        tick();
        checks++;
        if (r !== 16'hFFFF) begin
            failures++;
            $display("FAIL hold_update: r=%h expected=%h", r, 16'hFFFF);
        end
    endtask

    task automatic test_reset_priority();
        in0 = 16'd1;
        in2 = 16'hA5A5;
        set = 2'd0;
        tick();
        checks++;
        if (r !== 16'd1) begin
            failures++;
            $display("FAIL prio_setup: r=%h expected=%h", r, 16'd1);
        end
        reset = 1'b1;
        set = 2'd2;
        tick();
        checks++;
        if (r !== 16'h0000) begin
            failures++;
            $display("FAIL prio_reset: r=%h expected=%h", r, 16'h0000);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (r !== 16'hA5A5) begin
            failures++;
            $display("FAIL prio_release: r=%h expected=%h", r, 16'hA5A5);
        end
    endtask

    task automatic test_full_width();
        logic [15:0] exp_tab [3];
        exp_tab[0] = 16'h8000; exp_tab[1] = 16'h7FFF; exp_tab[2] = 16'hFFFF;
        in0 = 16'h8000; in1 = 16'h7FFF; in2 = 16'hFFFF;
        for (int s = 0; s < 3; s++) begin
            set = s[1:0];
            tick();
            checks++;
            if (r !== exp_tab[s]) begin
                failures++;
                $display("FAIL full_width set=%0d: r=%h expected=%h", s, r, exp_tab[s]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in0 = '0; in1 = '0; in2 = '0; set = '0;
        #1;
        test_reset();
        test_channel_sweep();
        test_illegal_wrap();
        test_latency_hold();
        test_reset_priority();
        test_full_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux16_b3.md
Name: mux16_b3

Overview:
- 3-to-1 multiplexer for 16-bit data with a registered output.
- Selects one of three 16-bit operands with a 2-bit select code.
- The result is registered on the rising clock edge.
- Used in the 16-bit processor datapath wherever a register-file, ALU or immediate operand must be chosen from three sources.

Parameters:
- WIDTH, 16, data width of every input and of the output; all behaviour below is stated for the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in0  input  16  operand for select code 0.
- in1  input  16  operand for select code 1.
- in2  input  16  operand for select code 2.
- set  input  2  select code.
- r  output  16  registered selected operand.
- sel_err  output  1  present only with MUX16B3_SEL_ERR_EN; flags an illegal select code.

Interface decision (already decided): one clock; reset is synchronous and active-high. The ports are named clk and reset.

Behaviour:
- Output r is a register. There are no combinational paths from inputs to outputs.
- On each rising edge of clk:
  - If reset=1: r <= 16'h0000; sel_err <= 0 (when present).
  - Else, r is loaded from the select code:
    - set=2'b00: r <= in0.
    - set=2'b01: r <= in1.
    - set=2'b10: r <= in2.
    - set=2'b11 (illegal code): r <= 16'h0000, deterministic.
- Latency: exactly 1 clock. The value sampled at edge N appears on r after edge N and holds until edge N+1.
- Reset has priority over any set/input change in the same cycle.
- Reset held for multiple cycles keeps r=0.
- Release of reset: the first non-reset edge loads the selected operand.
- Reset mid-stream discards the pending selection. No history is kept beyond the one output register.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.
- Width rule: data passes bit-exact, with no sign or zero extension.
- A select value driven wider than 2 bits by the instantiator is truncated to set[1:0].
  - Example: 4 wraps to 0, 5 to 1, 6 to 2, 7 to 3 (illegal).
- X/Z on set in simulation is a testbench error; no specific output is required in that case.
- No internal state besides r (and sel_err).
- Post-reset values: r=0 and sel_err=0 until the first non-reset edge.

Optional Feature:
- Macro: MUX16B3_SEL_ERR_EN.
- When defined:
  - Output sel_err exists and is registered alongside r.
  - sel_err <= 1 on any non-reset edge where set=2'b11; otherwise sel_err <= 0.
  - Reset clears it.
  - Simulation builds also emit a $display warning when an illegal code is sampled.
- When undefined:
  - The sel_err port and its logic are absent.
  - Illegal code still drives r <= 0 silently.
  - Port list is clk, reset, in0, in1, in2, set, r.

Test Plan:
- Reset: reset=1 for 3 edges with in0=1, in1=3, in2=7, set=0 -> r=0 throughout; first edge after release -> r=1.
- Channel sweep: in0=1, in1=3, in2=7; set 0,1,2 held 2 edges each -> r=1, 3, 7, each appearing one edge after the set change.
- Illegal/wrap: set=3 -> r=0 (sel_err=1 if enabled). Drive 4, 5, 6, 7 through a 3-bit source truncated to set -> r = 1, 3, 7, 0.
- Latency/hold: change in1 from 3 to 16'hFFFF mid-cycle with set=1 -> r stays 3 until the next edge, then 16'hFFFF.
- Reset priority: assert reset on the same edge that set changes 0->2 with in2=16'hA5A5 -> r=0; release -> r=16'hA5A5 next edge.
- Full-width data: in0=16'h8000, in1=16'h7FFF, in2=16'hFFFF -> r matches bit-exact for set 0, 1, 2.
